// File: rtl/spi_receiver_pkg.sv
// Shared definitions for the SPI receiver slice.
//   - DATA_WIDTH_DEF : default frame / FIFO word width
//   - s_*            : 2-bit FSM state encodings
//   - cnt_width()    : width of a counter that must hold 0..dw inclusive
package spi_receiver_pkg;

    localparam int DATA_WIDTH_DEF = 24;

    localparam logic [1:0] s_Idle    = 2'b00;
    localparam logic [1:0] s_Receive = 2'b01;
    localparam logic [1:0] s_Store   = 2'b10;
    localparam logic [1:0] s_WaitEnd = 2'b11;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_receiver_sync_edge_detect.sv
// Multi-stage synchronizer with single-cycle rise/fall pulses.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   din            : asynchronous input
//   dout           : synchronized level (last stage)
//   rise, fall     : one-cycle pulses on synchronized edges
// RESET_VAL sets the idle level so no spurious edge follows reset.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI peripheral-side receiver: MSB-first frames framed by active-low sync_n.
// Ports:
//   clock, reset_n : system clock (>= 4x sclk), async active-low reset
//   sclk, sdi      : serial clock (idles low) and data, sampled on sclk fall
//   sync_n         : frame select, active low
//   fifo_full      : downstream FIFO full
//   fifo_write     : one-cycle write strobe, data_out valid with it
//   data_out       : last stored word, held until the next store
//   frame_error    : pulse when sync_n rises before a full word
//   overflow       : pulse when a complete word is dropped on fifo_full
//   spi_busy       : high whenever the FSM is not idle
module spi_receiver
    import spi_receiver_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  sdi,
    input  logic                  sync_n,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_error,
    output logic                  overflow,
    output logic                  spi_busy
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic sclk_s, sclk_fall, unused_sclk_rise;
    logic sync_n_s, sync_n_fall, sync_n_rise;
    logic sdi_s, unused_sdi_rise, unused_sdi_fall;
    logic unused_sclk_s, unused_sync_n_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clock(clock), .reset_n(reset_n), .din(sclk),
        .dout(sclk_s), .rise(unused_sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_n (
        .clock(clock), .reset_n(reset_n), .din(sync_n),
        .dout(sync_n_s), .rise(sync_n_rise), .fall(sync_n_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
        .clock(clock), .reset_n(reset_n), .din(sdi),
        .dout(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
    );

    assign unused_sclk_s   = sclk_s;
    assign unused_sync_n_s = sync_n_s;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    // sync_n rose in the same cycle as the last bit: Store must exit to Idle,
    // otherwise WaitEnd would swallow the next frame's framing edge.
    logic                  end_seen;
    logic                  last_bit;

    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign spi_busy = (state != s_Idle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= s_Idle;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            end_seen    <= 1'b0;
            fifo_write  <= 1'b0;
            data_out    <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            fifo_write  <= 1'b0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
            case (state)
                s_Idle: begin
                    if (sync_n_fall) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        end_seen  <= 1'b0;
                        state     <= s_Receive;
                    end
                end
                s_Receive: begin
                    if (sclk_fall) begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], sdi_s};
                        bit_cnt   <= bit_cnt + CW'(1);
                    end
                    if (sclk_fall && last_bit) begin
                        state    <= s_Store;
                        end_seen <= sync_n_rise;
                    end else if (sync_n_rise) begin
                        frame_error <= 1'b1;
                        state       <= s_Idle;
                    end
                end
                s_Store: begin
                    if (!fifo_full) begin
                        fifo_write <= 1'b1;
                        data_out   <= shift_reg;
                    end else begin
                        overflow <= 1'b1;
                    end
                    state <= (end_seen || sync_n_rise) ? s_Idle : s_WaitEnd;
                end
                default: begin  // s_WaitEnd: trailing bits are ignored
                    if (sync_n_rise)
                        state <= s_Idle;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- SPI receiver (peripheral side) for 24-bit, MSB-first, no-parity frames framed by active-low sync_n.
- Samples the external sclk/sdi/sync_n with the system clock, assembles each complete word and pushes it into a downstream FIFO with a one-cycle write strobe.
- Sits at the link input, mirroring the team's SPI transmitter on the far end of the wire.
- Flags short frames and FIFO overflow as single-cycle error pulses.

Parameters:
- DATA_WIDTH, 24, bits per frame; also the FIFO word width.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, sdi and sync_n; minimum 2.

Ports:
- clock  input  1  system clock; must run at least 4x the sclk frequency.
- reset_n  input  1  asynchronous, active-low reset.
- sclk  input  1  external serial clock, asynchronous to clock; idles low.
- sdi  input  1  serial data; stable around the falling edge of sclk.
- sync_n  input  1  frame select, active low; high between frames.
- fifo_full  input  1  downstream FIFO full.
- fifo_write  output  1  one-cycle write strobe to the FIFO.
- data_out  output  DATA_WIDTH  received word; valid while fifo_write=1.
- frame_error  output  1  one-cycle pulse: sync_n rose before DATA_WIDTH bits were received.
- overflow  output  1  one-cycle pulse: a complete word was dropped because fifo_full=1.
- spi_busy  output  1  high in every state except s_Idle.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State s_Idle; bit counter 0; shift register 0.
  - All outputs 0: fifo_write, data_out, frame_error, overflow, spi_busy.
  - Synchronizer flops reset to idle levels: sclk=0, sdi=0, sync_n=1.
- Input conditioning:
  - Each external input passes through SYNC_STAGES flops.
  - Edge detection compares the last synchronized stage with one extra registered copy.
  - sclk_fall and sync_n_fall/sync_n_rise are single-cycle internal pulses.
- States:
  - s_Idle:
    - On sync_n_fall: clear the bit counter and shift register, go to s_Receive.
    - All sclk edges are ignored.
  - s_Receive:
    - On sclk_fall: shift register <= {shift[DATA_WIDTH-2:0], sdi_sync} (MSB first); counter increments.
    - When the counter reaches DATA_WIDTH after a shift: go to s_Store.
    - If sync_n_rise occurs with counter < DATA_WIDTH: pulse frame_error, discard the partial word, go to s_Idle.
  - s_Store (exactly one cycle):
    - If fifo_full=0: fifo_write=1 and data_out=shift register in that same cycle.
    - If fifo_full=1: overflow=1, fifo_write stays 0, word dropped.
    - Then go to s_WaitEnd.
  - s_WaitEnd:
    - Further sclk_fall edges are ignored; extra bits are discarded and raise no error.
    - On sync_n_rise: go to s_Idle.
- Simultaneous events:
  - sclk_fall on the last bit together with sync_n_rise in the same cycle: the bit is accepted, the word is stored, no frame_error; s_Store then proceeds directly to s_Idle.
  - sync_n_fall while in s_WaitEnd cannot occur without a preceding rise; there is no back-to-back frame without sync_n going high.
- Latency:
  - fifo_write asserts (SYNC_STAGES + 2) clock cycles after the falling sclk edge that carries the last bit.
- data_out:
  - Holds its value after the strobe until the next store.
  - Updates only in s_Store when fifo_full=0.
- Reset mid-frame: immediate return to s_Idle; no strobe or error pulse is emitted.
- sync_n held high: sclk activity never changes state or outputs.

Decomposition:
- Shared SPI package:
  - DATA_WIDTH default.
  - 2-bit state encodings: s_Idle=00, s_Receive=01, s_Store=10, s_WaitEnd=11.
  - Counter width: clog2(DATA_WIDTH+1).
- One natural sub-module: sync_edge_detect.
  - Multi-stage synchronizer plus rise/fall pulse outputs, parameterised by SYNC_STAGES.
  - Instantiated three times (sclk, sync_n, sdi with edge outputs unused).

Test Plan:
- Nominal frame: sync_n low, 24 bits 0xA5C3F0 MSB first at clock/8 sclk, sync_n high -> exactly one fifo_write with data_out=0xA5C3F0; frame_error=0 and overflow=0 throughout.
- Back-to-back frames: 0x000001, then 0xFFFFFF, then 0x800000, with a 4-clock sync_n high gap -> three strobes in that order with matching data.
- Short frame: sync_n rises after 10 bits -> one frame_error pulse, no fifo_write; next full frame 0x123456 received correctly.
- Overflow: fifo_full=1 held across the frame 0x654321 -> one overflow pulse, no fifo_write; data_out keeps its previous value.
- Extra bits: 30 sclk cycles within one sync_n low window carrying 0xDEADBE plus 6 junk bits -> one strobe with data_out=0xDEADBE, no error.
- Reset mid-frame: reset_n low after 12 bits -> outputs 0 immediately, no strobe; after release the next frame 0x0F0F0F is received correctly.
